// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: memory instruction port, redirect input and decode handshake.
interface if_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [9:0]       im_addr;
  logic [31:0]      im_dout;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [CNT_W-1:0] count;

  // The prefetch queue drives the memory address and the decode-facing outputs.
  modport master (
    output im_addr, out_valid, out_instr, out_pc, count,
    input  im_dout, redirect_valid, redirect_pc, out_ready
  );

  // The surrounding pipeline/memory drives data, redirects and decode readiness.
  modport slave (
    input  im_addr, out_valid, out_instr, out_pc, count,
    output im_dout, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, snapshots the combinational
// instruction word into a small FIFO and hands {pc, instr} to decode.
// Redirects flush the queue and restart fetch at the new PC.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             entries [DEPTH];
  entry_t             head;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               full;
  logic               not_empty;
  logic               enq;
  logic               deq;

  // Handshake decode: redirect suppresses both enqueue and dequeue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    full      = 1'b0;
    not_empty = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    full      = (count_q == CNT_W'(DEPTH));
    not_empty = (count_q != '0);
    deq       = not_empty & bus.out_ready & ~bus.redirect_valid;
    enq       = ~bus.redirect_valid & (~full | deq);
  end

  // Fetch PC, pointers and occupancy; reset beats redirect, redirect beats enq/deq.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      fetch_pc <= RESET_PC & ~32'h3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~32'h3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Entry storage: snapshot {pc, instr} at enqueue time.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; outputs are gated by count, so stale entries are never visible.
    if (!rst && enq) begin
      entries[wr_ptr] <= '{pc: fetch_pc, instr: bus.im_dout};
    end
  end

  assign head          = entries[rd_ptr];
  assign bus.im_addr   = fetch_pc[11:2];
  assign bus.out_valid = not_empty;
  assign bus.out_instr = not_empty ? head.instr : 32'h0;
  assign bus.out_pc    = not_empty ? head.pc    : 32'h0;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: expected {pc, instr} pairs are
// queued when fetch is started/redirected and compared on each handshake.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] mem [1024];
  exp_t        sb [$];
  int          n_cmp;
  int          n_err;

  if_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational instruction memory model.
  assign bus.im_dout = mem[bus.im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start_pc, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start_pc + 32'(4 * i);
      sb.push_back('{pc: pc, instr: mem[pc[11:2]]});
    end
  endtask

  // Compare the head on a handshake at the current (negedge) sample, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (!rst && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("head", {bus.out_pc, bus.out_instr}, {e.pc, e.instr});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_instr", 64'(bus.out_instr), 64'd0);
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h13 + 32'(i);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    tick();
    check("rst_valid0", 64'(bus.out_valid), 64'd0);
    check("rst_pc0", 64'(bus.out_pc), 64'd0);
    check("rst_addr0", 64'(bus.im_addr), 64'd0);

    // 1: streaming after reset release.
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push_seq(32'h0, 6);
    check("t1_valid_pre", 64'(bus.out_valid), 64'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("t1_valid", 64'(bus.out_valid), 64'd1);
      tick();
    end
    check("t1_sb_drained", 64'(sb.size()), 64'd0);

    // 2: stall fills the queue and holds.
    bus.out_ready = 1'b0;
    do_reset();
    push_seq(32'h0, 8);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      check("t2_count", 64'(bus.count), 64'(k));
    end
    tick();
    tick();
    check("t2_count_hold", 64'(bus.count), 64'(DEPTH));
    check("t2_addr_hold", 64'(bus.im_addr), 64'd4);
    check("t2_pc_hold", 64'(bus.out_pc), 64'd0);
    check("t2_instr_hold", 64'(bus.out_instr), 64'h13);

    // 3: full queue, one-cycle dequeue with simultaneous enqueue.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t3_count", 64'(bus.count), 64'(DEPTH));
    check("t3_pc", 64'(bus.out_pc), 64'h4);
    check("t3_addr", 64'(bus.im_addr), 64'd5);

    // 4: redirect with three entries queued and decode ready.
    do_reset();
    push_seq(32'h0, 3);
    for (int k = 0; k < 3; k++) tick();
    check("t4_count3", 64'(bus.count), 64'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    bus.out_ready      = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'h100, 4);
    check("t4_count0", 64'(bus.count), 64'd0);
    check("t4_valid0", 64'(bus.out_valid), 64'd0);
    check("t4_addr", 64'(bus.im_addr), 64'h040);
    tick();
    check("t4_pc", 64'(bus.out_pc), 64'h100);
    for (int k = 0; k < 3; k++) tick();

    // 5: redirect to the top of the address space, PC wraps to 0.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'hFFFF_FFFC, 3);
    check("t5_addr_top", 64'(bus.im_addr), 64'h3FF);
    tick();
    check("t5_pc_top", 64'(bus.out_pc), 64'hFFFF_FFFC);
    check("t5_addr_wrap", 64'(bus.im_addr), 64'h000);
    tick();
    check("t5_pc_wrap", 64'(bus.out_pc), 64'h0);
    tick();

    // 6: reset beats a pending redirect on a full queue.
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    check("t6_full", 64'(bus.count), 64'(DEPTH));
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    tick();
    check("t6_count", 64'(bus.count), 64'd0);
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_instr", 64'(bus.out_instr), 64'd0);
    check("t6_addr", 64'(bus.im_addr), 64'd0);
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'h0, 4);
    tick();
    check("t6_pc_after", 64'(bus.out_pc), 64'h0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
